// File: rtl/fg_prog_sequencer.sv
// ---------------------------------------------------------------------------
// fg_prog_sequencer
//   Drives the program/run pins and the gate/drain address and enable lines
//   of a floating-gate island for one injection pulse per command.
//   Sequence: IDLE -> SETUP (SETTLE_CYC) -> SELECT (1) -> PULSE (cmd_width)
//             -> HOLD (HOLD_CYC) -> IDLE (done pulse).
//
// Parameters
//   SETTLE_CYC : cycles in program mode before the gate select (1..255)
//   HOLD_CYC   : cycles addresses are held after the pulse (1..255)
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid / cmd_ready : command handshake (ready only in IDLE)
//   cmd_row, cmd_col      : drain row / gate column, latched on accept
//   cmd_width             : pulse width in cycles (0 skips the pulse)
//   abort                 : end the sequence early (SETUP/SELECT/PULSE only)
//   prog, run             : island mode pins
//   gate_en, gate_b       : GateEnable, GateB[1:0]
//   drain_en, drain_b     : DrainEnable, DrainB[4:0]
//   busy, done, aborted   : status; done is a one-cycle pulse, aborted is
//                           valid with done and cleared on the next accept
//   pulse_count           : only with FG_PROG_PULSE_COUNT_EN defined; counts
//                           completed, non-aborted sequences with width > 0,
//                           saturating at 65535
//
// Optional feature macro: FG_PROG_PULSE_COUNT_EN
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module fg_prog_sequencer #(
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned HOLD_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_row,
  input  logic [1:0]  cmd_col,
  input  logic [15:0] cmd_width,
  input  logic        abort,
  output logic        prog,
  output logic        run,
  output logic        gate_en,
  output logic [1:0]  gate_b,
  output logic        drain_en,
  output logic [4:0]  drain_b,
  output logic        busy,
  output logic        done,
  output logic        aborted
`ifdef FG_PROG_PULSE_COUNT_EN
  ,
  output logic [15:0] pulse_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SELECT,
    PULSE,
    HOLD
  } state_e;

  // Counters are loaded with (length - 1) and the phase ends when they read 0,
  // so a width of 65535 fits the 16-bit counter and runs in full.
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] width_q, width_d;
  logic [1:0]  gate_b_q, gate_b_d;
  logic [4:0]  drain_b_q, drain_b_d;
  logic        aborted_q, aborted_d;
  logic        done_q, done_d;
  logic        prog_q, prog_d;
  logic        run_q, run_d;
  logic        gate_en_q, gate_en_d;
  logic        drain_en_q, drain_en_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
`ifdef FG_PROG_PULSE_COUNT_EN
  logic [15:0] pulse_count_q, pulse_count_d;
`endif

  logic accept;
  logic abortable;

  assign accept    = cmd_valid && cmd_ready_q;
  assign abortable = (state_q == SETUP) || (state_q == SELECT) || (state_q == PULSE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    gate_b_d  = gate_b_q;
    drain_b_d = drain_b_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;

    if (abortable && abort) begin
      state_d   = HOLD;
      cnt_d     = HOLD_LOAD;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = SETUP;
            cnt_d     = SETTLE_LOAD;
            width_d   = cmd_width;
            gate_b_d  = cmd_col;
            drain_b_d = cmd_row;
            aborted_d = 1'b0;
          end
        end
        SETUP: begin
          if (cnt_q == '0) state_d = SELECT;
          else             cnt_d   = cnt_q - 16'd1;
        end
        SELECT: begin
          if (width_q == '0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = PULSE;
            cnt_d   = width_q - 16'd1;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    prog_d      = (state_d != IDLE);
    run_d       = (state_d == IDLE);
    gate_en_d   = (state_d == SELECT) || (state_d == PULSE);
    drain_en_d  = (state_d == PULSE);
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);

`ifdef FG_PROG_PULSE_COUNT_EN
    pulse_count_d = pulse_count_q;
    if (done_d && !aborted_q && (width_q != '0) && (pulse_count_q != 16'hFFFF))
      pulse_count_d = pulse_count_q + 16'd1;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and also clears the latched addresses and
    // width, so a command seen together with rst is never taken.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      gate_b_q    <= '0;
      drain_b_q   <= '0;
      aborted_q   <= 1'b0;
      done_q      <= 1'b0;
      prog_q      <= 1'b0;
      run_q       <= 1'b1;
      gate_en_q   <= 1'b0;
      drain_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
`ifdef FG_PROG_PULSE_COUNT_EN
      pulse_count_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // the values from before this edge.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      gate_b_q    <= gate_b_d;
      drain_b_q   <= drain_b_d;
      aborted_q   <= aborted_d;
      done_q      <= done_d;
      prog_q      <= prog_d;
      run_q       <= run_d;
      gate_en_q   <= gate_en_d;
      drain_en_q  <= drain_en_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef FG_PROG_PULSE_COUNT_EN
      pulse_count_q <= pulse_count_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign prog      = prog_q;
  assign run       = run_q;
  assign gate_en   = gate_en_q;
  assign gate_b    = gate_b_q;
  assign drain_en  = drain_en_q;
  assign drain_b   = drain_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
`ifdef FG_PROG_PULSE_COUNT_EN
  assign pulse_count = pulse_count_q;
`endif

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fg_prog_sequencer
//   Self-checking bench for fg_prog_sequencer. The reference model works from
//   the sequence timeline: for a command accepted at the end of cycle T it
//   derives the phase of every later cycle from SETTLE/HOLD lengths, the
//   width and the abort point, and compares all outputs every cycle.
// ---------------------------------------------------------------------------
module tb_fg_prog_sequencer;

  localparam int S = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_row;
  logic [1:0]  cmd_col;
  logic [15:0] cmd_width;
  logic        abort;
  logic        prog, run, gate_en, drain_en, busy, done, aborted;
  logic [1:0]  gate_b;
  logic [4:0]  drain_b;
`ifdef FG_PROG_PULSE_COUNT_EN
  logic [15:0] pulse_count;
`endif

  fg_prog_sequencer #(.SETTLE_CYC(S), .HOLD_CYC(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_width (cmd_width),
    .abort     (abort),
    .prog      (prog),
    .run       (run),
    .gate_en   (gate_en),
    .gate_b    (gate_b),
    .drain_en  (drain_en),
    .drain_b   (drain_b),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
`ifdef FG_PROG_PULSE_COUNT_EN
    ,
    .pulse_count (pulse_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [1:0] exp_gate_b;
  logic [4:0] exp_drain_b;
  bit         last_aborted;
  int         model_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {prog,run,gate_en,drain_en,busy,done,cmd_ready,gate_b,drain_b}.
  task automatic expect_outs(input string tag, input bit e_prog, input bit e_run,
                             input bit e_ge, input bit e_de, input bit e_busy,
                             input bit e_done, input bit e_rdy);
    check(tag,
          32'({prog, run, gate_en, drain_en, busy, done, cmd_ready, gate_b, drain_b}),
          32'({e_prog, e_run, e_ge, e_de, e_busy, e_done, e_rdy, exp_gate_b, exp_drain_b}));
  endtask

  task automatic check_pc(input string tag);
`ifdef FG_PROG_PULSE_COUNT_EN
    check(tag, 32'(pulse_count), 32'(model_pc));
`endif
  endtask

  task automatic randomize_cmd();
    cmd_row   = 5'($urandom);
    cmd_col   = 2'($urandom);
    cmd_width = 16'($urandom);
  endtask

  // Two reset cycles with a command offered; nothing may be accepted.
  task automatic do_reset(input string tag);
    rst       = 1'b1;
    cmd_valid = 1'b1;
    abort     = 1'b0;
    randomize_cmd();
    exp_gate_b   = '0;
    exp_drain_b  = '0;
    last_aborted = 1'b0;
    model_pc     = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      expect_outs(tag, 0, 1, 0, 0, 0, 0, 1);
      check({tag, "_aborted"}, 32'(aborted), 32'd0);
      check_pc({tag, "_pc"});
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      abort     = 1'($urandom);
      randomize_cmd();
      step();
      expect_outs("idle", 0, 1, 0, 0, 0, 0, 1);
      check("idle_aborted", 32'(aborted), 32'(last_aborted));
    end
    abort = 1'b0;
  endtask

  // Entered in an IDLE cycle; offers the command this cycle. abort_at / rst_at
  // are cycle offsets after accept (0 = none). Returns in the done cycle.
  task automatic run_seq(input logic [4:0] row, input logic [1:0] col,
                         input logic [15:0] w, input int abort_at,
                         input bit keep_valid, input int rst_at);
    int last_act, done_at, wi;
    wi        = int'(w);
    cmd_valid = 1'b1;
    cmd_row   = row;
    cmd_col   = col;
    cmd_width = w;
    abort     = 1'($urandom);   // abort in IDLE must be ignored
    exp_gate_b  = col;
    exp_drain_b = row;
    last_act = (abort_at > 0) ? abort_at : S + 1 + wi;
    done_at  = last_act + H + 1;
    for (int d = 1; d <= done_at; d++) begin
      step();
      if (d <= last_act) begin
        if (d <= S)          expect_outs("setup", 1, 0, 0, 0, 1, 0, 0);
        else if (d == S + 1) expect_outs("select", 1, 0, 1, 0, 1, 0, 0);
        else                 expect_outs("pulse", 1, 0, 1, 1, 1, 0, 0);
      end else if (d < done_at) begin
        expect_outs("hold", 1, 0, 0, 0, 1, 0, 0);
      end else begin
        expect_outs("done", 0, 1, 0, 0, 0, 1, 1);
      end
      if (d == 1) check("aborted_clear", 32'(aborted), 32'd0);
      if (d == done_at) begin
        last_aborted = (abort_at > 0);
        if (!last_aborted && wi > 0 && model_pc < 65535) model_pc++;
        check("done_aborted", 32'(aborted), 32'(last_aborted));
        check_pc("done_pc");
        cmd_valid = 1'b0;
        abort     = 1'b0;
        return;
      end
      if (d == rst_at) begin
        do_reset("rst_mid");
        return;
      end
      cmd_valid = keep_valid ? 1'b1 : 1'($urandom);
      randomize_cmd();
      if (d == abort_at)   abort = 1'b1;
      else if (d > last_act) abort = 1'($urandom);  // ignored in HOLD
      else                 abort = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, a;
    bit kv;
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_row = '0; cmd_col = '0; cmd_width = '0;
    model_pc = 0; last_aborted = 1'b0;
    exp_gate_b = '0; exp_drain_b = '0;

    do_reset("reset");
    idle_cycles(2);

    // Directed: row 5, col 2, width 3.
    run_seq(5'd5, 2'd2, 16'd3, 0, 1'b0, 0);
    idle_cycles(2);
    // Width 0: select then hold.
    run_seq(5'd17, 2'd1, 16'd0, 0, 1'b0, 0);
    idle_cycles(1);
    // Width 100, abort at 10th pulse cycle.
    run_seq(5'd9, 2'd3, 16'd100, S + 11, 1'b0, 0);
    idle_cycles(2);
    // Abort during SETUP and during SELECT.
    run_seq(5'd1, 2'd0, 16'd7, 1, 1'b0, 0);
    run_seq(5'd30, 2'd1, 16'd7, S + 1, 1'b0, 0);
    idle_cycles(1);
    // cmd_valid held high: back-to-back accepts at the done cycles.
    run_seq(5'd3, 2'd2, 16'd5, 0, 1'b1, 0);
    run_seq(5'd4, 2'd1, 16'd2, 0, 1'b1, 0);
    run_seq(5'd6, 2'd3, 16'd1, 0, 1'b0, 0);
    idle_cycles(2);

    // Randomized sequences.
    for (int i = 0; i < 30; i++) begin
      w  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      a  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, S + 1 + w)) : 0;
      kv = 1'($urandom);
      run_seq(5'($urandom), 2'($urandom), 16'(w), a, kv, 0);
      if (!kv) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);

    // Reset in the middle of a pulse, then a normal sequence.
    run_seq(5'd21, 2'd2, 16'd20, 0, 1'b0, S + 6);
    idle_cycles(2);
    run_seq(5'd11, 2'd1, 16'd2, 0, 1'b0, 0);
    idle_cycles(1);

    // Maximum width is honoured in full.
    run_seq(5'd31, 2'd3, 16'hFFFF, 0, 1'b0, 0);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
